// File: rtl/alu_control_mc_if.sv
// Handshake and result bus between the issue stage and the EX-stage ALU control unit.
interface alu_control_mc_if #(
    parameter int unsigned ALUOP_W = 4,
    parameter int unsigned FUNCT_W = 6,
    parameter int unsigned CTRL_W  = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [ALUOP_W-1:0] ALUOp;
    logic [FUNCT_W-1:0] funct;
    logic               flush;
    logic [CTRL_W-1:0]  alu_ctrl;
    logic               out_valid;
    logic               illegal;
    logic               mc_busy;
    logic               mc_start;
    logic               mc_done;

    modport master (
        output in_valid, ALUOp, funct, flush,
        input  in_ready, alu_ctrl, out_valid, illegal, mc_busy, mc_start, mc_done
    );

    modport slave (
        input  in_valid, ALUOp, funct, flush,
        output in_ready, alu_ctrl, out_valid, illegal, mc_busy, mc_start, mc_done
    );
endinterface

// File: rtl/alu_control_mc.sv
// EX-stage ALU control: decodes ALUOp/funct into an ALU code and sequences
// the iterative MULT/DIV unit through a fixed-length IDLE -> RUN -> DONE run.
module alu_control_mc #(
    parameter int unsigned ALUOP_W    = 4,
    parameter int unsigned FUNCT_W    = 6,
    parameter int unsigned CTRL_W     = 4,
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 8
) (
    input  logic               clk,
    input  logic               rst,
    alu_control_mc_if.slave    bus
);

    localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [CTRL_W-1:0] alu_ctrl_q,  alu_ctrl_d;
    logic              out_valid_q, out_valid_d;
    logic              illegal_q,   illegal_d;
    logic              mc_busy_q,   mc_busy_d;
    logic              mc_start_q,  mc_start_d;
    logic              mc_done_q,   mc_done_d;

    logic [CTRL_W-1:0] dec_code;
    logic              dec_illegal;
    logic              dec_mc;
    logic [CNT_W-1:0]  dec_last;
    logic              accept;

    function automatic logic [CTRL_W-1:0] code(input logic [3:0] c);
        return CTRL_W'(c);
    endfunction

    // Decode the presented op; anything unlisted is illegal and single-cycle.
    always_comb begin
        dec_code    = '1;
        dec_illegal = 1'b1;
        dec_mc      = 1'b0;
        dec_last    = '0;
        case (bus.ALUOp)
            ALUOP_W'(3'd0): begin dec_code = code(4'b0111); dec_illegal = 1'b0; end
            ALUOP_W'(3'd1): begin dec_code = code(4'b0100); dec_illegal = 1'b0; end
            ALUOP_W'(3'd3): begin dec_code = code(4'b0110); dec_illegal = 1'b0; end
            ALUOP_W'(3'd4): begin dec_code = code(4'b0101); dec_illegal = 1'b0; end
            ALUOP_W'(3'd5): begin dec_code = code(4'b1000); dec_illegal = 1'b0; end
            ALUOP_W'(3'd2): begin
                case (bus.funct)
                    FUNCT_W'(6'b000111): begin dec_code = code(4'b0111); dec_illegal = 1'b0; end
                    FUNCT_W'(6'b000100): begin dec_code = code(4'b0100); dec_illegal = 1'b0; end
                    FUNCT_W'(6'b000110): begin dec_code = code(4'b0110); dec_illegal = 1'b0; end
                    FUNCT_W'(6'b000101): begin dec_code = code(4'b0101); dec_illegal = 1'b0; end
                    FUNCT_W'(6'b000000): begin dec_code = code(4'b0000); dec_illegal = 1'b0; end
                    FUNCT_W'(6'b000001): begin dec_code = code(4'b0001); dec_illegal = 1'b0; end
                    FUNCT_W'(6'b000010): begin dec_code = code(4'b0010); dec_illegal = 1'b0; end
                    FUNCT_W'(6'b000011): begin dec_code = code(4'b0011); dec_illegal = 1'b0; end
                    FUNCT_W'(6'b001000): begin dec_code = code(4'b1000); dec_illegal = 1'b0; end
                    FUNCT_W'(6'b011000): begin
                        dec_code    = code(4'b1001);
                        dec_illegal = 1'b0;
                        dec_mc      = 1'b1;
                        dec_last    = CNT_W'(MUL_CYCLES - 1);
                    end
                    FUNCT_W'(6'b011010): begin
                        dec_code    = code(4'b1010);
                        dec_illegal = 1'b0;
                        dec_mc      = 1'b1;
                        dec_last    = CNT_W'(DIV_CYCLES - 1);
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign accept = bus.in_valid & (state_q == IDLE) & ~bus.flush;

    // Next state and registered outputs; flush overrides everything except alu_ctrl.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_ctrl_d  = alu_ctrl_q;
        out_valid_d = 1'b0;
        illegal_d   = 1'b0;
        mc_busy_d   = 1'b0;
        mc_start_d  = 1'b0;
        mc_done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    alu_ctrl_d = dec_code;
                    if (dec_mc) begin
                        state_d    = RUN;
                        cnt_d      = dec_last;
                        mc_busy_d  = 1'b1;
                        mc_start_d = 1'b1;
                    end else begin
                        out_valid_d = 1'b1;
                        illegal_d   = dec_illegal;
                    end
                end
            end
            RUN: begin
                if (cnt_q == '0) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    mc_done_d   = 1'b1;
                end else begin
                    cnt_d     = cnt_q - CNT_W'(1);
                    mc_busy_d = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.flush) begin
            state_d     = IDLE;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            illegal_d   = 1'b0;
            mc_busy_d   = 1'b0;
            mc_start_d  = 1'b0;
            mc_done_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            alu_ctrl_q  <= '0;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            mc_busy_q   <= 1'b0;
            mc_start_q  <= 1'b0;
            mc_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_ctrl_q  <= alu_ctrl_d;
            out_valid_q <= out_valid_d;
            illegal_q   <= illegal_d;
            mc_busy_q   <= mc_busy_d;
            mc_start_q  <= mc_start_d;
            mc_done_q   <= mc_done_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.alu_ctrl  = alu_ctrl_q;
    assign bus.out_valid = out_valid_q;
    assign bus.illegal   = illegal_q;
    assign bus.mc_busy   = mc_busy_q;
    assign bus.mc_start  = mc_start_q;
    assign bus.mc_done   = mc_done_q;

endmodule
